// File: rtl/typed_fifo.sv
// typed_fifo: first-word-fall-through FIFO carrying an arbitrary element type.
// Occupancy is tracked explicitly, so DEPTH need not be a power of two.
module typed_fifo #(
  parameter type T = bit [7:0],
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  parameter bit [CW-1:0] AFULL = CW'(DEPTH - 1),
  parameter bit [CW-1:0] AEMPTY = CW'(1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  T              in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output T              out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          almost_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_afull;
  logic          r_aempty;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_nxt;
  logic [PW-1:0] w_wptr_inc;
  logic [PW-1:0] w_rptr_inc;

  // Status outputs come straight from registered state only.
  assign in_ready     = (r_count != FULLC);
  assign out_valid    = (r_count != '0);
  assign out_data     = r_mem[r_rptr];
  assign count        = r_count;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  assign w_wptr_inc = (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
  assign w_rptr_inc = (r_rptr == LAST) ? '0 : r_rptr + PW'(1);

  // Next occupancy; flush wins over any handshake in the same cycle.
  always_comb begin
    w_cnt_nxt = r_count;
    if (flush) begin
      w_cnt_nxt = '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   w_cnt_nxt = r_count + CW'(1);
        2'b01:   w_cnt_nxt = r_count - CW'(1);
        default: w_cnt_nxt = r_count;
      endcase
    end
  end

  // Pointers, occupancy and threshold flags, all from the next count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_afull  <= (AFULL == '0);
      r_aempty <= 1'b1;
    end else begin
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= w_wptr_inc;
        if (w_pop)  r_rptr <= w_rptr_inc;
      end
      r_count  <= w_cnt_nxt;
      r_afull  <= (w_cnt_nxt >= AFULL);
      r_aempty <= (w_cnt_nxt <= AEMPTY);
    end
  end

  // Storage is never cleared; only pointers define what is live.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_push) r_mem[r_wptr] <= in_data;
  end

endmodule

// File: tb/tb_typed_fifo.sv
// tb_typed_fifo: directed scoreboard bench for typed_fifo.
// Three instances: byte/depth 8, byte/depth 5, packed struct/depth 4.
module tb_typed_fifo;

  typedef struct packed {
    bit [3:0]  a;
    bit [12:0] b;
  } s_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: DEPTH 8
  logic       a_rst_n, a_flush, a_in_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic       a_in_ready, a_out_valid, a_af, a_ae;
  logic [3:0] a_count;

  typed_fifo #(.DEPTH(8)) u_a (
    .clk(clk), .rst_n(a_rst_n), .flush(a_flush),
    .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .count(a_count), .almost_full(a_af),
    .almost_empty(a_ae)
  );

  // Instances B and C share a reset
  logic rst_bc;

  logic       b_in_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic       b_in_ready, b_out_valid, b_af, b_ae;
  logic [2:0] b_count;

  typed_fifo #(.DEPTH(5)) u_b (
    .clk(clk), .rst_n(rst_bc), .flush(1'b0),
    .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .count(b_count), .almost_full(b_af),
    .almost_empty(b_ae)
  );

  logic       c_in_valid, c_out_ready;
  s_t         c_in_data, c_out_data;
  logic       c_in_ready, c_out_valid, c_af, c_ae;
  logic [2:0] c_count;

  typed_fifo #(
    .T(s_t), .DEPTH(4), .AFULL(3), .AEMPTY(0)
  ) u_c (
    .clk(clk), .rst_n(rst_bc), .flush(1'b0),
    .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .count(c_count), .almost_full(c_af),
    .almost_empty(c_ae)
  );

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  s_t         qc[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc_a(input bit wv, input logic [7:0] wd,
                       input bit rr, input bit fl,
                       input bit rn);
    bit push, pop;
    a_in_valid  = wv;
    a_in_data   = wd;
    a_out_ready = rr;
    a_flush     = fl;
    a_rst_n     = rn;
    if (qa.size() != 0) begin
      chk("a_valid_pre", {31'd0, a_out_valid}, 1);
      chk("a_head", {24'd0, a_out_data}, {24'd0, qa[0]});
    end
    push = wv && (qa.size() != 8);
    pop  = rr && (qa.size() != 0);
    @(posedge clk);
    #1;
    if (!rn || fl) begin
      qa.delete();
    end else begin
      if (pop)  void'(qa.pop_front());
      if (push) qa.push_back(wd);
    end
    chk("a_count", {28'd0, a_count}, qa.size());
    chk("a_in_ready", {31'd0, a_in_ready},
        {31'd0, qa.size() != 8});
    chk("a_out_valid", {31'd0, a_out_valid},
        {31'd0, qa.size() != 0});
    chk("a_afull", {31'd0, a_af}, {31'd0, qa.size() >= 7});
    chk("a_aempty", {31'd0, a_ae}, {31'd0, qa.size() <= 1});
  endtask

  task automatic cyc_b(input bit wv, input logic [7:0] wd,
                       input bit rr);
    bit push, pop;
    b_in_valid  = wv;
    b_in_data   = wd;
    b_out_ready = rr;
    if (qb.size() != 0)
      chk("b_head", {24'd0, b_out_data}, {24'd0, qb[0]});
    push = wv && (qb.size() != 5);
    pop  = rr && (qb.size() != 0);
    @(posedge clk);
    #1;
    if (pop)  void'(qb.pop_front());
    if (push) qb.push_back(wd);
    chk("b_count", {29'd0, b_count}, qb.size());
    chk("b_out_valid", {31'd0, b_out_valid},
        {31'd0, qb.size() != 0});
  endtask

  task automatic cyc_c(input bit wv, input s_t wd,
                       input bit rr);
    bit push, pop;
    c_in_valid  = wv;
    c_in_data   = wd;
    c_out_ready = rr;
    if (qc.size() != 0) begin
      chk("c_field_a", {28'd0, c_out_data.a}, {28'd0, qc[0].a});
      chk("c_field_b", {19'd0, c_out_data.b}, {19'd0, qc[0].b});
    end
    push = wv && (qc.size() != 4);
    pop  = rr && (qc.size() != 0);
    @(posedge clk);
    #1;
    if (pop)  void'(qc.pop_front());
    if (push) qc.push_back(wd);
    chk("c_count", {29'd0, c_count}, qc.size());
    chk("c_in_ready", {31'd0, c_in_ready},
        {31'd0, qc.size() != 4});
    chk("c_afull", {31'd0, c_af}, {31'd0, qc.size() >= 3});
    chk("c_aempty", {31'd0, c_ae}, {31'd0, qc.size() == 0});
  endtask

  initial begin
    s_t sv;
    a_rst_n = 1'b0; a_flush = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    rst_bc = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;

    // Reset, including handshakes held during reset
    cyc_a(0, 8'h00, 0, 0, 0);
    cyc_a(1, 8'h33, 1, 1, 0);
    rst_bc = 1'b1;

    // Pop request while empty is ignored
    cyc_a(0, 8'h00, 1, 0, 1);

    // Fill to full, then a write that must be dropped
    for (int i = 1; i <= 8; i++) cyc_a(1, 8'(i), 0, 0, 1);
    cyc_a(1, 8'h09, 0, 0, 1);
    cyc_a(0, 8'h00, 0, 0, 1);
    cyc_a(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc_a(0, 8'h00, 1, 0, 1);

    // Full with write and pop together: only the pop lands
    for (int i = 0; i < 8; i++) cyc_a(1, 8'h40 + 8'(i), 0, 0, 1);
    cyc_a(1, 8'h99, 1, 0, 1);
    cyc_a(1, 8'h77, 1, 0, 1);
    for (int i = 0; i < 4; i++) cyc_a(0, 8'h00, 1, 0, 1);

    // Flush with 3 stored beats a same-cycle write and pop
    cyc_a(1, 8'hEE, 1, 1, 1);
    cyc_a(0, 8'h00, 0, 0, 1);

    // Reset mid-operation with 6 entries
    for (int i = 0; i < 6; i++) cyc_a(1, 8'h10 + 8'(i), 0, 0, 1);
    cyc_a(1, 8'h5A, 1, 0, 0);
    cyc_a(1, 8'hA5, 0, 0, 1);
    cyc_a(0, 8'h00, 0, 0, 1);
    cyc_a(0, 8'h00, 1, 0, 1);

    // DEPTH 5: 1:1 interleave wraps pointers several times
    cyc_b(1, 8'd1, 0);
    for (int k = 2; k <= 12; k++) cyc_b(1, 8'(k), 1);
    cyc_b(0, 8'd0, 1);
    for (int k = 0; k < 7; k++) cyc_b(1, 8'h80 + 8'(k), 0);
    for (int k = 0; k < 6; k++) cyc_b(0, 8'd0, 1);

    // Packed struct element type
    for (int i = 0; i < 4; i++) begin
      sv.a = 4'(i * 5 + 3);
      sv.b = 13'(i * 1931 + 4097);
      cyc_c(1, sv, 0);
    end
    sv.a = 4'hF;
    sv.b = 13'h1FFF;
    cyc_c(1, sv, 0);
    for (int i = 0; i < 4; i++) cyc_c(0, sv, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/typed_fifo.md
TYPED_FIFO -- requirements
Module: typed_fifo

Interface
REQ-001 SHALL have parameter T: type, default bit [7:0], element type carried through the FIFO.
REQ-002 SHALL have parameter DEPTH: int, default 8, number of storage entries; legal range 2..1024, not required to be a power of two.
REQ-003 SHALL derive localparam CW = $clog2(DEPTH+1), the width of occupancy values.
REQ-004 SHALL have parameter AFULL: bit [CW-1:0], default DEPTH-1, almost-full threshold; its type depends on DEPTH.
REQ-005 SHALL have parameter AEMPTY: bit [CW-1:0], default 1, almost-empty threshold.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset: one clock; reset is synchronous and active-low.
REQ-008 SHALL have port flush  input  1  synchronous clear of contents.
REQ-009 SHALL have port in_data  input  T  write element.
REQ-010 SHALL have port in_valid  input  1  write request.
REQ-011 SHALL have port in_ready  output  1  FIFO can accept a write this cycle.
REQ-012 SHALL have port out_data  output  T  head element.
REQ-013 SHALL have port out_valid  output  1  head element present.
REQ-014 SHALL have port out_ready  input  1  consumer takes head this cycle.
REQ-015 SHALL have port count  output  CW  current occupancy, 0..DEPTH.
REQ-016 SHALL have port almost_full  output  1  count >= AFULL.
REQ-017 SHALL have port almost_empty  output  1  count <= AEMPTY.

Function
REQ-018 SHALL accept a write when in_valid && in_ready at a rising edge; a pop when out_valid && out_ready.
REQ-019 SHALL drive in_ready = (count != DEPTH), combinational from registered count only; no dependence on out_ready.
REQ-020 SHALL drive out_valid = (count != 0) and out_data = storage at read pointer, first-word-fall-through.
REQ-021 SHALL show a write to an empty FIFO on out_valid/out_data in the cycle after acceptance (latency 1).
REQ-022 SHALL keep write and read pointers in 0..DEPTH-1, wrapping from DEPTH-1 to 0 for any DEPTH.
REQ-023 SHALL on simultaneous write and pop update both pointers and leave count unchanged.
REQ-024 SHALL when full ignore in_valid (in_ready low); a pop while full raises in_ready the next cycle, no same-cycle bypass.
REQ-025 SHALL when empty never pop; out_ready is ignored while out_valid is low.
REQ-026 SHALL on flush high set pointers and count to 0 next cycle, taking priority over any same-cycle write or pop; storage contents need not clear.
REQ-027 SHALL hold out_data stable while out_valid && !out_ready.
REQ-028 SHALL register almost_full and almost_empty from the next-state count, so they agree with count every cycle.
REQ-029 SHALL compare thresholds unsigned at width CW; AFULL > DEPTH keeps almost_full low; AEMPTY >= DEPTH keeps almost_empty high.
REQ-030 SHALL support any T, including packed structs and multi-dimensional packed types, without T-specific logic.

Reset
REQ-031 SHALL on rst_n low at a rising edge set count=0, pointers=0, almost_full=(AFULL==0), almost_empty=1; reset overrides flush and handshakes.
REQ-032 SHALL during reset present in_ready=1, out_valid=0; out_data undefined while out_valid=0.
REQ-033 SHALL on reset mid-operation discard all contents; first post-reset write observed as first post-reset read.

Verification
REQ-034 T=bit[7:0], DEPTH=8: write 0x01..0x08 without popping -> count=8, in_ready=0, almost_full=1 from count 7; 9th write ignored; pops return 0x01..0x08 in order.
REQ-035 DEPTH=5: 12 writes interleaved 1:1 with pops -> pointers wrap at 4->0, count stays <=1, data order preserved.
REQ-036 Full FIFO, in_valid=1 and out_ready=1 same cycle -> only pop accepted, count 8->7, in_ready=1 next cycle.
REQ-037 3 entries stored, flush=1 with in_valid=1 and out_ready=1 -> count=0, out_valid=0 next cycle, neither write nor pop takes effect.
REQ-038 T=struct packed {bit [3:0] a; bit [12:0] b;}, DEPTH=4, AFULL=3, AEMPTY=0: write 4 structs -> fields returned unmodified; almost_empty low after first write.
REQ-039 rst_n low for 1 cycle with 6 entries stored -> count=0, out_valid=0, almost_empty=1 next cycle; write 0xA5 -> out_data=0xA5 one cycle later.
